// File: rtl/ps2_uart_sched.sv
// rtl/ps2_uart_sched.sv - PS/2 scan-code FIFO and UART character sequencer.
// Captures scan codes on ps2_state rising edges and emits them as ASCII hex (or raw) via a tx_start/tx_busy handshake.
module ps2_uart_sched #(
  parameter int FIFO_AW     = 2,
  parameter bit HEX_MODE    = 1'b1,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [7:0]         i_ps2_byte,
  input  logic               i_ps2_state,
  input  logic               i_tx_busy,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  output logic               o_overflow,
  output logic [FIFO_AW:0]   o_fifo_cnt
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_LOAD, S_START, S_WAIT_ACK, S_WAIT_DONE
  } state_t;

  state_t               r_state;
  logic                 r_prev;
  logic [7:0]           r_mem [DEPTH];
  logic [FIFO_AW-1:0]   r_wr_ptr;
  logic [FIFO_AW-1:0]   r_rd_ptr;
  logic [FIFO_AW:0]     r_cnt;
  logic [7:0]           r_cur;
  logic                 r_brk;
  logic [7:0]           r_chars [4];
  logic [2:0]           r_nchar;
  logic [1:0]           r_idx;
  logic [TW-1:0]        r_tmo;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_accept;
  logic                 w_last;
  logic [7:0]           w_head;
  logic                 w_prefix;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign w_push     = i_ps2_state & ~r_prev;
  assign w_pop      = (r_state == S_POP);
  assign w_full     = (r_cnt == (FIFO_AW+1)'(DEPTH));
  // A full FIFO still accepts when the same edge frees the head slot.
  assign w_accept   = w_push & (~w_full | w_pop);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_prefix   = (w_head == 8'hF0) || (w_head == 8'hE0);
  assign w_last     = (({1'b0, r_idx} + 3'd1) == r_nchar);
  assign o_fifo_cnt = r_cnt;

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= i_ps2_byte;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev     <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      o_overflow <= 1'b0;
    end else begin
      r_prev <= i_ps2_state;
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_push && !w_accept) begin
        o_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_cur      <= 8'h00;
      r_brk      <= 1'b0;
      r_chars[0] <= 8'h00;
      r_chars[1] <= 8'h00;
      r_chars[2] <= 8'h00;
      r_chars[3] <= 8'h00;
      r_nchar    <= 3'd0;
      r_idx      <= 2'd0;
      r_tmo      <= '0;
      o_tx_data  <= 8'h00;
      o_tx_start <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_cnt != '0) begin
            r_state <= S_POP;
          end
        end
        S_POP: begin
          r_cur <= w_head;
          r_idx <= 2'd0;
          if (HEX_MODE) begin
            r_chars[0] <= hex_char(w_head[7:4]);
            r_chars[1] <= hex_char(w_head[3:0]);
            r_chars[3] <= 8'h0A;
            if (w_prefix) begin
              r_chars[2] <= 8'h20;
              r_nchar    <= 3'd3;
              if (w_head == 8'hF0) begin
                r_brk <= 1'b1;
              end
            end else if (r_brk) begin
              r_chars[2] <= 8'h0D;
              r_nchar    <= 3'd4;
              r_brk      <= 1'b0;
            end else begin
              r_chars[2] <= 8'h20;
              r_nchar    <= 3'd3;
            end
          end else begin
            r_chars[0] <= w_head;
            r_nchar    <= 3'd1;
          end
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          // Output registers land together so tx_start is high exactly in START.
          o_tx_data  <= r_chars[r_idx];
          o_tx_start <= 1'b1;
          r_state    <= S_START;
        end
        S_START: begin
          r_tmo   <= '0;
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (i_tx_busy) begin
            r_state <= S_WAIT_DONE;
          end else if (r_tmo == TW'(ACK_TIMEOUT - 1)) begin
            if (w_last) begin
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 2'd1;
              r_state <= S_LOAD;
            end
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!i_tx_busy) begin
            if (w_last) begin
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 2'd1;
              r_state <= S_LOAD;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_uart_sched.sv
// tb/tb_ps2_uart_sched.sv - scoreboard bench for ps2_uart_sched.
// Expected characters are queued as scan codes are driven and compared on every tx_start pulse.
module tb_ps2_uart_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ps2_byte = 8'h00;
  logic       ps2_state = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       overflow;
  logic [2:0] fifo_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] exp_q[$];
  bit tb_brk = 0;
  bit model_en = 0;

  ps2_uart_sched #(.FIFO_AW(2), .HEX_MODE(1'b1), .ACK_TIMEOUT(15)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ps2_byte(ps2_byte), .i_ps2_state(ps2_state),
    .i_tx_busy(tx_busy), .o_tx_data(tx_data), .o_tx_start(tx_start),
    .o_overflow(overflow), .o_fifo_cnt(fifo_cnt)
  );

  always #10 clk = ~clk;

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h41 + {4'h0, n - 4'd10};
  endfunction

  task automatic push_exp(input logic [7:0] b);
    exp_q.push_back(hexc(b[7:4]));
    exp_q.push_back(hexc(b[3:0]));
    if (b == 8'hF0 || b == 8'hE0) begin
      exp_q.push_back(8'h20);
      if (b == 8'hF0) tb_brk = 1;
    end else if (tb_brk) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      tb_brk = 0;
    end else begin
      exp_q.push_back(8'h20);
    end
  endtask

  // Scoreboard: every tx_start pops one expected character.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_tx_start: got tx_data=%02h, required no pulse", tx_data);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e) $display("FAIL tx_char: got %02h, required %02h", tx_data, e);
          else pass_cnt++;
        end
      end
    end
  end

  // UART model: busy rises 2 clocks after tx_start and stays high for 20 clocks.
  initial begin
    forever begin
      @(negedge clk);
      if (model_en && tx_start) begin
        @(negedge clk);
        @(negedge clk);
        tx_busy = 1'b1;
        repeat (20) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic push_byte(input logic [7:0] b, input bit expect_it);
    @(negedge clk);
    ps2_byte  = b;
    ps2_state = 1'b1;
    if (expect_it) push_exp(b);
    @(negedge clk);
    ps2_state = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || tx_busy || fifo_cnt != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (30) @(negedge clk);
    total_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL %s_drain: got %0d chars outstanding, required 0", name, exp_q.size());
    else pass_cnt++;
  endtask

  task automatic manual_char();
    int n = 0;
    while (!tx_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (!tx_start) $display("FAIL manual_tx_start: got no pulse, required pulse");
    else pass_cnt++;
    tx_busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tx_busy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({tx_start, tx_data, overflow, fifo_cnt} !== {1'b0, 8'h00, 1'b0, 3'd0})
      $display("FAIL reset_values: got start=%b data=%02h ovf=%b cnt=%0d, required 0/00/0/0",
               tx_start, tx_data, overflow, fifo_cnt);
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_press();
    model_en = 1;
    @(negedge clk);
    ps2_byte  = 8'h1C;
    ps2_state = 1'b1;
    push_exp(8'h1C);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ps2_state = 1'b0;
      total_cnt++;
      if (tx_start !== (i == 3))
        $display("FAIL latency_%0d: got tx_start=%b, required %b", i, tx_start, (i == 3));
      else pass_cnt++;
    end
    wait_drain("single_press");
  endtask

  task automatic test_release();
    push_byte(8'hF0, 1);
    push_byte(8'h1C, 1);
    wait_drain("release");
    push_byte(8'h1C, 1);
    wait_drain("press_after_release");
    push_byte(8'hE0, 1);
    push_byte(8'h75, 1);
    wait_drain("extended");
  endtask

  task automatic test_overflow();
    int n = 0;
    model_en = 0;
    tx_busy  = 1'b1;
    push_byte(8'h11, 1);
    while (!tx_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    push_byte(8'h22, 1);
    push_byte(8'h33, 1);
    push_byte(8'h44, 1);
    push_byte(8'h55, 1);
    total_cnt++;
    if (fifo_cnt !== 3'd4 || overflow !== 1'b0)
      $display("FAIL fill: got cnt=%0d ovf=%b, required cnt=4 ovf=0", fifo_cnt, overflow);
    else pass_cnt++;
    push_byte(8'h66, 0);
    total_cnt++;
    if (fifo_cnt !== 3'd4 || overflow !== 1'b1)
      $display("FAIL drop: got cnt=%0d ovf=%b, required cnt=4 ovf=1", fifo_cnt, overflow);
    else pass_cnt++;
    // Step the remaining characters of 0x11 by hand so the next pop edge is known.
    @(negedge clk);
    tx_busy = 1'b0;
    manual_char();
    manual_char();
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (fifo_cnt !== 3'd4) $display("FAIL full_before_pop: got cnt=%0d, required 4", fifo_cnt);
    else pass_cnt++;
    ps2_byte  = 8'h77;
    ps2_state = 1'b1;
    push_exp(8'h77);
    @(negedge clk);
    ps2_state = 1'b0;
    total_cnt++;
    if (fifo_cnt !== 3'd4) $display("FAIL push_pop_full: got cnt=%0d, required 4", fifo_cnt);
    else pass_cnt++;
    model_en = 1;
    wait_drain("overflow");
    total_cnt++;
    if (overflow !== 1'b1) $display("FAIL overflow_sticky: got %b, required 1", overflow);
    else pass_cnt++;
  endtask

  task automatic test_no_ack();
    model_en = 0;
    tx_busy  = 1'b0;
    push_byte(8'h1C, 1);
    push_byte(8'h5A, 1);
    wait_drain("no_ack");
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    model_en = 1;
    push_byte(8'hF0, 1);
    while (!tx_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (!tx_busy) $display("FAIL mid_frame_busy: got busy=0, required 1");
    else pass_cnt++;
    rst_n = 1'b0;
    exp_q.delete();
    tb_brk = 0;
    #1;
    total_cnt++;
    if ({tx_start, tx_data, overflow, fifo_cnt} !== {1'b0, 8'h00, 1'b0, 3'd0})
      $display("FAIL mid_frame_reset: got start=%b data=%02h ovf=%b cnt=%0d, required 0/00/0/0",
               tx_start, tx_data, overflow, fifo_cnt);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    n = 0;
    while (tx_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    push_byte(8'h2A, 1);
    wait_drain("after_reset");
    @(negedge clk);
    rst_n     = 1'b0;
    ps2_byte  = 8'h3B;
    ps2_state = 1'b1;
    push_exp(8'h3B);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ps2_state = 1'b0;
    wait_drain("level_at_reset");
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_release();
    test_overflow();
    test_no_ack();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
